fmul_share_arbiter: RTL

- Shares one float_multiplier instance among NUM_REQ requesters using round-robin arbitration.
- Sequences the multiplier's start/done handshake and holds its operands stable for the whole operation.
- Returns each result to the requester that issued it, tagged with that requester's ID.
- Includes a watchdog so a hung multiplier cannot stall all requesters.

---
 rtl/fmul_share_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fmul_share_arbiter.sv
// Round-robin arbiter that shares one multi-cycle float multiplier among NUM_REQ
// requesters, routes each product back by ID, and substitutes a quiet NaN on a hang.
module fmul_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_result,
    output logic                  resp_timeout,
    output logic                  mul_start,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [31:0]           mul_result,
    input  logic                  mul_done,
    output logic                  busy,
    output logic                  timeout_err,
    input  logic                  err_clr
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       res_q, res_d;
    logic              tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_REQ-1:0][31:0] a_vec, b_vec;
    logic                     any_req;
    logic [ID_W-1:0]          grant_id;
    logic [ID_W:0]            idx;

    assign a_vec = req_a;
    assign b_vec = req_b;

    // Walk from ptr upward with wrap; iterating downward lets the closest hit win.
    always_comb begin
        any_req  = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ))
                idx = idx - (ID_W+1)'(NUM_REQ);
            if (req_valid[idx[ID_W-1:0]]) begin
                any_req  = 1'b1;
                grant_id = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && any_req)
            req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        err_d   = err_clr ? 1'b0 : err_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    a_d     = a_vec[grant_id];
                    b_d     = b_vec[grant_id];
                    id_d    = grant_id;
                    state_d = S_ISSUE;
                end
            end
            // mul_done is deliberately not looked at here: it may be left over.
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mul_done) begin
                    res_d   = mul_result;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = QNAN;
                    tmo_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mul_start    = (state_q == S_ISSUE);
    assign mul_a        = a_q;
    assign mul_b        = b_q;
    assign resp_valid   = (state_q == S_RESP);
    assign resp_id      = id_q;
    assign resp_result  = res_q;
    assign resp_timeout = tmo_q;
    assign busy         = (state_q != S_IDLE);
    assign timeout_err  = err_q;
endmodule
